lcd_text_ctrl: RTL and testbench

//  Parametrised HD44780-class character-LCD controller, 8-bit bus, write-only (LCD_RW tied 0).

---
 rtl/lcd_text_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_ctrl.sv
// HD44780-class character LCD controller, 8-bit write-only bus.
// Runs the power-on init sequence, then refreshes the panel from an internal
// ROWS x COLS frame buffer that the host writes through WR_EN/WR_ADDR/WR_DATA.
// Optional feature: define LCD_DIRTY_EN to refresh only rows written since their
// last transmission; otherwise every row is resent continuously.
module lcd_text_ctrl #(
    parameter longint unsigned CLK_HZ = 50_000_000,
    parameter int unsigned     COLS   = 16,
    parameter int unsigned     ROWS   = 2,
    parameter int unsigned     POR_US = 15000,
    parameter int unsigned     CMD_US = 40,
    parameter int unsigned     CLR_US = 1640,
    parameter int unsigned     E_CYC  = 12,
    localparam int unsigned    NCHARS = COLS * ROWS,
    localparam int unsigned    AW     = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
    input  logic          CLK_50MHZ,
    input  logic          RST,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [7:0]    WR_DATA,
    output logic          READY,
    output logic          BUSY,
    output logic [7:0]    LCD_DB,
    output logic          LCD_E,
    output logic          LCD_RS,
    output logic          LCD_RW
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    // Microseconds to clock cycles, rounded up, never zero.
    function automatic logic [31:0] us2cyc(input longint unsigned us);
        longint unsigned c;
        c = (us * CLK_HZ + 64'd999_999) / 64'd1_000_000;
        if (c == 64'd0) c = 64'd1;
        return c[31:0];
    endfunction

    localparam logic [31:0] POR_CYC = us2cyc(64'(POR_US));
    localparam logic [31:0] CMD_CYC = us2cyc(64'(CMD_US));
    localparam logic [31:0] CLR_CYC = us2cyc(64'(CLR_US));
    localparam logic [31:0] W1_CYC  = us2cyc(64'd4100);
    localparam logic [31:0] W2_CYC  = us2cyc(64'd100);

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        case (i)
            3'd4:    return 8'h0C;
            3'd5:    return 8'h01;
            3'd6:    return 8'h06;
            default: return 8'h38;
        endcase
    endfunction

    function automatic logic [31:0] init_wait(input logic [2:0] i);
        case (i)
            3'd0:    return W1_CYC;
            3'd1:    return W2_CYC;
            3'd5:    return CLR_CYC;
            default: return CMD_CYC;
        endcase
    endfunction

    function automatic logic [7:0] row_cmd(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    function automatic logic [AW-1:0] row_base(input logic [1:0] r);
        logic [31:0] b;
        b = 32'(r) * 32'(COLS);
        return b[AW-1:0];
    endfunction

    typedef enum logic [2:0] {TPor, TInit, TIdle, TRowCmd, TChars} top_e;
    typedef enum logic [2:0] {BIdle, BSetup, BPulse, BHold, BWait} bus_e;

    top_e          top_q, top_d;
    bus_e          bus_st_q, bus_st_d;
    logic [31:0]   por_cnt_q, por_cnt_d, bus_cnt_q, bus_cnt_d, wait_q, wait_d;
    logic [AW:0]   fill_q, fill_d;
    logic [2:0]    init_idx_q, init_idx_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    db_q, db_d;
    logic          rs_q, rs_d, e_q, ready_q, ready_d;
    logic          bus_start, start_rs, bus_done, char_rd, fill_done, fill_we, wr_ok;
    logic [7:0]    start_byte, rd_data;
    logic [31:0]   start_wait;
    logic          go_row;
    logic [1:0]    go_row_idx;
    logic [7:0]    mem_q [NCHARS];

    assign fill_done = (fill_q == (AW + 1)'(NCHARS));
    assign fill_we   = (top_q == TPor) && !fill_done;
    assign wr_ok     = WR_EN && (32'(WR_ADDR) < 32'(NCHARS));
    assign rd_data   = mem_q[addr_q];
    assign bus_done  = (bus_st_q == BWait) && (bus_cnt_q == wait_q - 32'd1);
    // Character byte is fetched combinationally in the first SETUP cycle, so a
    // same-cycle host write lands in the buffer while the old value goes out.
    assign char_rd   = (bus_st_q == BSetup) && (bus_cnt_q == 32'd0) && rs_q;

`ifdef LCD_DIRTY_EN
    logic [ROWS-1:0] dirty_q, dirty_d;
    logic [31:0]     dirty_from;
    logic            dirty_hit, set_all;
    logic [1:0]      dirty_row, wr_row;

    // Lowest dirty row at or above the search start (row 0 from IDLE, next row from CHARS).
    always_comb begin
        dirty_from = (top_q == TChars) ? 32'(row_q) + 32'd1 : 32'd0;
        dirty_hit  = 1'b0;
        dirty_row  = 2'd0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (dirty_q[r] && (32'(r) >= dirty_from)) begin
                dirty_hit = 1'b1;
                dirty_row = 2'(r);
            end
        end
    end

    // Row of the incoming write: last row whose base is not above the address.
    always_comb begin
        wr_row = 2'd0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (32'(WR_ADDR) >= 32'(r) * 32'(COLS)) wr_row = 2'(r);
        end
    end

    // Dirty-row register.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) dirty_q <= '0;
        else     dirty_q <= dirty_d;
    end
`endif

    // Frame buffer: POR fill has the port until every entry holds a space.
    always_ff @(posedge CLK_50MHZ) begin
        if (fill_we)    mem_q[fill_q[AW-1:0]] <= 8'h20;
        else if (wr_ok) mem_q[WR_ADDR] <= WR_DATA;
    end

    // Top sequencer: POR wait, init bytes, then row command / character refresh.
    always_comb begin
        top_d      = top_q;
        por_cnt_d  = por_cnt_q;
        fill_d     = fill_q;
        init_idx_d = init_idx_q;
        row_d      = row_q;
        col_d      = col_q;
        addr_d     = addr_q;
        ready_d    = ready_q;
        bus_start  = 1'b0;
        start_byte = 8'h00;
        start_rs   = 1'b0;
        start_wait = CMD_CYC;
        go_row     = 1'b0;
        go_row_idx = 2'd0;
`ifdef LCD_DIRTY_EN
        dirty_d    = dirty_q;
        set_all    = 1'b0;
`endif
        unique case (top_q)
            TPor: begin
                if (!fill_done) fill_d = fill_q + 1'b1;
                if (por_cnt_q != POR_CYC - 32'd1) begin
                    por_cnt_d = por_cnt_q + 32'd1;
                end else if (fill_done) begin
                    bus_start  = 1'b1;
                    start_byte = init_byte(3'd0);
                    start_wait = init_wait(3'd0);
                    init_idx_d = 3'd0;
                    top_d      = TInit;
                end
            end
            TInit: begin
                if (bus_done) begin
                    if (init_idx_q == 3'd6) begin
                        top_d   = TIdle;
                        ready_d = 1'b1;
`ifdef LCD_DIRTY_EN
                        set_all = 1'b1;
`endif
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                        bus_start  = 1'b1;
                        start_byte = init_byte(init_idx_d);
                        start_wait = init_wait(init_idx_d);
                    end
                end
            end
            TIdle: begin
`ifdef LCD_DIRTY_EN
                go_row     = dirty_hit;
                go_row_idx = dirty_row;
`else
                go_row     = 1'b1;
`endif
            end
            TRowCmd: begin
                if (bus_done) begin
                    bus_start = 1'b1;
                    start_rs  = 1'b1;
                    top_d     = TChars;
                end
            end
            TChars: begin
                if (bus_done) begin
                    if (col_q == CW'(COLS - 1)) begin
`ifdef LCD_DIRTY_EN
                        go_row     = dirty_hit;
                        go_row_idx = dirty_row;
                        if (!dirty_hit) top_d = TIdle;
`else
                        if (row_q == 2'(ROWS - 1)) begin
                            top_d = TIdle;
                        end else begin
                            go_row     = 1'b1;
                            go_row_idx = row_q + 2'd1;
                        end
`endif
                    end else begin
                        col_d     = col_q + 1'b1;
                        addr_d    = addr_q + 1'b1;
                        bus_start = 1'b1;
                        start_rs  = 1'b1;
                    end
                end
            end
            default: top_d = TPor;
        endcase

        if (go_row) begin
            bus_start  = 1'b1;
            start_byte = row_cmd(go_row_idx);
            row_d      = go_row_idx;
            col_d      = '0;
            addr_d     = row_base(go_row_idx);
            top_d      = TRowCmd;
`ifdef LCD_DIRTY_EN
            dirty_d[go_row_idx] = 1'b0;
`endif
        end
`ifdef LCD_DIRTY_EN
        // A write re-marks its row even if that row's command just started.
        if (set_all) dirty_d = '1;
        if (wr_ok)   dirty_d[wr_row] = 1'b1;
`endif
    end

    // Bus cycle: SETUP 2 cycles, E pulse, HOLD 1 cycle, then execution wait.
    always_comb begin
        bus_st_d  = bus_st_q;
        bus_cnt_d = bus_cnt_q + 32'd1;
        db_d      = db_q;
        rs_d      = rs_q;
        wait_d    = wait_q;
        unique case (bus_st_q)
            BIdle:  bus_cnt_d = '0;
            BSetup: begin
                if (char_rd) db_d = rd_data;
                if (bus_cnt_q == 32'd1) begin
                    bus_st_d  = BPulse;
                    bus_cnt_d = '0;
                end
            end
            BPulse: begin
                if (bus_cnt_q == 32'(E_CYC - 1)) begin
                    bus_st_d  = BHold;
                    bus_cnt_d = '0;
                end
            end
            BHold: begin
                bus_st_d  = BWait;
                bus_cnt_d = '0;
            end
            BWait: begin
                if (bus_done) begin
                    bus_st_d  = BIdle;
                    bus_cnt_d = '0;
                end
            end
            default: bus_st_d = BIdle;
        endcase
        if (bus_start) begin
            bus_st_d  = BSetup;
            bus_cnt_d = '0;
            db_d      = start_byte;
            rs_d      = start_rs;
            wait_d    = start_wait;
        end
    end

    // State registers; reset restarts the whole init sequence.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            top_q      <= TPor;
            bus_st_q   <= BIdle;
            por_cnt_q  <= '0;
            fill_q     <= '0;
            init_idx_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            bus_cnt_q  <= '0;
            wait_q     <= '0;
            db_q       <= 8'h00;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            top_q      <= top_d;
            bus_st_q   <= bus_st_d;
            por_cnt_q  <= por_cnt_d;
            fill_q     <= fill_d;
            init_idx_q <= init_idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            bus_cnt_q  <= bus_cnt_d;
            wait_q     <= wait_d;
            db_q       <= db_d;
            rs_q       <= rs_d;
            e_q        <= (bus_st_d == BPulse);
            ready_q    <= ready_d;
        end
    end

    assign READY  = ready_q;
    assign BUSY   = (bus_st_q != BIdle);
    assign LCD_DB = char_rd ? rd_data : db_q;
    assign LCD_E  = e_q;
    assign LCD_RS = rs_q;
    assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Self-checking bench for lcd_text_ctrl: a 16x2 instance (A) and a 20x4
// instance (B), both at 1 MHz so one microsecond is one cycle.
`timescale 1ns/1ps
module tb_lcd_text_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, wr_en_a, ready_a, busy_a, e_a, rs_a, rw_a;
    logic [4:0] wr_addr_a;
    logic [7:0] wr_data_a, db_a;
    logic       rst_b, wr_en_b, ready_b, busy_b, e_b, rs_b, rw_b;
    logic [6:0] wr_addr_b;
    logic [7:0] wr_data_b, db_b;

    lcd_text_ctrl #(.CLK_HZ(64'd1_000_000), .COLS(16), .ROWS(2), .POR_US(100)) dut_a (
        .CLK_50MHZ(clk), .RST(rst_a), .WR_EN(wr_en_a), .WR_ADDR(wr_addr_a),
        .WR_DATA(wr_data_a), .READY(ready_a), .BUSY(busy_a), .LCD_DB(db_a),
        .LCD_E(e_a), .LCD_RS(rs_a), .LCD_RW(rw_a)
    );

    lcd_text_ctrl #(.CLK_HZ(64'd1_000_000), .COLS(20), .ROWS(4), .POR_US(100)) dut_b (
        .CLK_50MHZ(clk), .RST(rst_b), .WR_EN(wr_en_b), .WR_ADDR(wr_addr_b),
        .WR_DATA(wr_data_b), .READY(ready_b), .BUSY(busy_b), .LCD_DB(db_b),
        .LCD_E(e_b), .LCD_RS(rs_b), .LCD_RW(rw_b)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Scoreboards: {rw, rs, db} expected at each rising E.
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    logic [7:0] model_a[32];
    logic [7:0] model_b[80];
    logic [7:0] init_tab[7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    logic [7:0] row_tab[4]  = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    int unsigned gap_tab[6] = '{4115, 115, 55, 55, 55, 1655};

    // Monitor A: byte check at each E rise, pulse width at each E fall.
    logic        prev_e_a = 1'b0;
    int          ehi_a = 0;
    bit          skip_w_a = 1'b0;
    int          rise_idx_a = 0;
    int          rises_a = 0;
    int unsigned init_rise_a[7];
    logic [9:0]  mon_a;
    always @(negedge clk) begin
        if (e_a && !prev_e_a) begin
            if (rise_idx_a < 7) init_rise_a[rise_idx_a] = cyc;
            rise_idx_a++;
            rises_a++;
            if (exp_a.size() > 0) begin
                mon_a = exp_a.pop_front();
                check_eq("a_byte", {22'd0, rw_a, rs_a, db_a}, {22'd0, mon_a});
            end
        end
        if (e_a) ehi_a++;
        else if (prev_e_a) begin
            if (skip_w_a) skip_w_a = 1'b0;
            else check_eq("a_e_width", ehi_a, 12);
            ehi_a = 0;
        end
        prev_e_a = e_a;
    end

    // Monitor B.
    logic       prev_e_b = 1'b0;
    int         ehi_b = 0;
    logic [9:0] mon_b;
    always @(negedge clk) begin
        if (e_b && !prev_e_b && exp_b.size() > 0) begin
            mon_b = exp_b.pop_front();
            check_eq("b_byte", {22'd0, rw_b, rs_b, db_b}, {22'd0, mon_b});
        end
        if (e_b) ehi_b++;
        else if (prev_e_b) begin
            check_eq("b_e_width", ehi_b, 12);
            ehi_b = 0;
        end
        prev_e_b = e_b;
    end

    task automatic wr_a(input int addr, input logic [7:0] d);
        @(negedge clk);
        wr_en_a = 1'b1; wr_addr_a = 5'(addr); wr_data_a = d;
        @(negedge clk);
        wr_en_a = 1'b0;
        if (addr < 32) model_a[addr] = d;
    endtask

    task automatic wr_b(input int addr, input logic [7:0] d);
        @(negedge clk);
        wr_en_b = 1'b1; wr_addr_b = 7'(addr); wr_data_b = d;
        @(negedge clk);
        wr_en_b = 1'b0;
        if (addr < 80) model_b[addr] = d;
    endtask

    task automatic push_init_a();
        for (int i = 0; i < 7; i++) exp_a.push_back({2'b00, init_tab[i]});
    endtask

    task automatic push_row_a(input int r);
        exp_a.push_back({2'b00, row_tab[r]});
        for (int c = 0; c < 16; c++) exp_a.push_back({2'b01, model_a[r * 16 + c]});
    endtask

    task automatic push_pass_b();
        for (int r = 0; r < 4; r++) begin
            exp_b.push_back({2'b00, row_tab[r]});
            for (int c = 0; c < 20; c++) exp_b.push_back({2'b01, model_b[r * 20 + c]});
        end
    endtask

    task automatic drain_a(input int budget);
        int n = 0;
        while (exp_a.size() > 0 && n < budget) begin @(posedge clk); n++; end
        check_eq("a_drain_left", exp_a.size(), 0);
    endtask

    task automatic drain_b(input int budget);
        int n = 0;
        while (exp_b.size() > 0 && n < budget) begin @(posedge clk); n++; end
        check_eq("b_drain_left", exp_b.size(), 0);
    endtask

    // Called #1 after the edge where reset was released; counts edges to first E.
    task automatic first_e_a();
        int cnt = 0;
        int noisy = 0;
        while (cnt < 300) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (e_a) break;
            if (ready_a || rw_a) noisy++;
        end
        check_eq("a_first_e_cycle", cnt, 102);
        check_eq("a_por_quiet", noisy, 0);
        check_eq("a_first_byte", {23'd0, rs_a, db_a}, 32'h038);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned rdy_cyc;
        int r0;
        rst_a = 1'b1; rst_b = 1'b1;
        wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        for (int i = 0; i < 32; i++) model_a[i] = 8'h20;
        for (int i = 0; i < 80; i++) model_b[i] = 8'h20;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_e", {30'd0, e_a, e_b}, 0);
        check_eq("rst_ready", {30'd0, ready_a, ready_b}, 0);
        check_eq("rst_busy", {30'd0, busy_a, busy_b}, 0);
        check_eq("rst_db_rs_rw", {14'd0, db_a, rs_a, rw_a}, 0);

        push_init_a();
        for (int i = 0; i < 7; i++) exp_b.push_back({2'b00, init_tab[i]});
        rst_a = 1'b0; rst_b = 1'b0;
        first_e_a();

        // Host writes land during init, after the POR fill.
        wr_a(17, 8'h41);
        wr_a(0, 8'h48);
        wr_b(80, 8'h5A);
        wr_b(100, 8'h5B);
        wr_b(79, 8'h7E);
        wr_b(20, 8'h31);
        push_row_a(0); push_row_a(1);
`ifndef LCD_DIRTY_EN
        push_row_a(0); push_row_a(1);
`endif
        push_pass_b();

        n = 0;
        while (!ready_a && n < 20000) begin @(negedge clk); n++; end
        rdy_cyc = cyc;
        check_eq("a_ready_seen", {31'd0, ready_a}, 1);
        check_eq("a_ready_latency", rdy_cyc - init_rise_a[6], 53);
        for (int k = 0; k < 6; k++)
            check_eq("a_init_gap", init_rise_a[k + 1] - init_rise_a[k], gap_tab[k]);

        drain_a(20000);
        drain_b(30000);

`ifdef LCD_DIRTY_EN
        r0 = rises_a;
        repeat (10000) @(posedge clk);
        #1;
        check_eq("a_idle_pulses", rises_a - r0, 0);
        check_eq("a_idle_busy_e", {30'd0, busy_a, e_a}, 0);
        r0 = rises_a;
        wr_a(0, 8'h55);
        push_row_a(0);
        drain_a(5000);
        repeat (2000) @(posedge clk);
        check_eq("a_dirty_pulses", rises_a - r0, 17);
`else
        r0 = 0;
`endif

        // Reset in the middle of a character E pulse.
        wr_a(5, 8'h20);
        n = 0;
        while (!(e_a && rs_a) && n < 5000) begin @(negedge clk); n++; end
        check_eq("a_char_pulse_found", {31'd0, e_a && rs_a}, 1);
        skip_w_a = 1'b1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check_eq("a_rst_e_drop", {31'd0, e_a}, 0);
        check_eq("a_rst_ready", {30'd0, ready_a, busy_a}, 0);
        exp_a.delete();
        for (int i = 0; i < 32; i++) model_a[i] = 8'h20;
        push_init_a();
        push_row_a(0); push_row_a(1);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rise_idx_a = 0;
        first_e_a();
        drain_a(20000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
